// File: rtl/mem_write_checker.sv
// Scoreboard for the data-memory write port: checks an ordered list of expected
// (address, data) stores and reports PASS, FAIL (with error code and capture) or TIMEOUT.
module mem_write_checker #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_CHECKS = 1,
    parameter logic [NUM_CHECKS*ADDR_W-1:0] EXP_ADDR = 84,
    parameter logic [NUM_CHECKS*DATA_W-1:0] EXP_DATA = 7,
    parameter bit          IGNORE_EN   = 1'b1,
    parameter logic [ADDR_W-1:0] IGNORE_ADDR = 80,
    parameter int unsigned TIMEOUT    = 150,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned MW        = $clog2(NUM_CHECKS + 1)
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              en_i,
    input  logic              memwrite_i,
    input  logic [ADDR_W-1:0] dataadr_i,
    input  logic [DATA_W-1:0] writedata_i,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic [1:0]        err_code_o,
    output logic [MW-1:0]     match_cnt_o,
    output logic [7:0]        ign_cnt_o,
    output logic [CNT_W-1:0]  cycles_o,
    output logic [ADDR_W-1:0] err_addr_o,
    output logic [DATA_W-1:0] err_data_o
);

    typedef enum logic [1:0] {StRun, StPass, StFail} state_e;

    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
    localparam logic [MW-1:0]    LastIdx     = MW'(NUM_CHECKS - 1);

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrAddr    = 2'd1;
    localparam logic [1:0] ErrData    = 2'd2;
    localparam logic [1:0] ErrTimeout = 2'd3;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [MW-1:0]     match_q, match_d;
    logic [7:0]        ign_q, ign_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [DATA_W-1:0] err_data_q, err_data_d;

    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              is_scratch;

    // Select the expected entry addressed by the match count (static slices only).
    always_comb begin
        exp_addr = '0;
        exp_data = '0;
        for (int i = 0; i < int'(NUM_CHECKS); i++) begin
            if (match_q == MW'(i)) begin
                exp_addr = EXP_ADDR[i*ADDR_W +: ADDR_W];
                exp_data = EXP_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign is_scratch = IGNORE_EN && (dataadr_i == IGNORE_ADDR);

    // Next-state: store classification in priority order, then the timeout check.
    always_comb begin
        state_d    = state_q;
        cycles_d   = cycles_q;
        match_d    = match_q;
        ign_d      = ign_q;
        err_code_d = err_code_q;
        err_addr_d = err_addr_q;
        err_data_d = err_data_q;

        if (state_q == StRun && en_i) begin
            cycles_d = cycles_q + 1'b1;
            if (memwrite_i && is_scratch) begin
                if (ign_q != 8'hFF) begin
                    ign_d = ign_q + 8'd1;
                end
            end else if (memwrite_i && dataadr_i == exp_addr && writedata_i == exp_data) begin
                match_d = match_q + 1'b1;
                if (match_q == LastIdx) begin
                    state_d = StPass;
                end
            end else if (memwrite_i) begin
                state_d    = StFail;
                err_code_d = (dataadr_i == exp_addr) ? ErrData : ErrAddr;
                err_addr_d = dataadr_i;
                err_data_d = writedata_i;
            end

            // A completing store or a store error already left RUN and takes precedence.
            if (state_d == StRun && cycles_q == TimeoutLast) begin
                state_d    = StFail;
                err_code_d = ErrTimeout;
                err_addr_d = '0;
                err_data_d = '0;
            end
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= StRun;
            cycles_q   <= '0;
            match_q    <= '0;
            ign_q      <= '0;
            err_code_q <= ErrNone;
            err_addr_q <= '0;
            err_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cycles_q   <= cycles_d;
            match_q    <= match_d;
            ign_q      <= ign_d;
            err_code_q <= err_code_d;
            err_addr_q <= err_addr_d;
            err_data_q <= err_data_d;
        end
    end

    assign pass_o      = (state_q == StPass);
    assign fail_o      = (state_q == StFail);
    assign done_o      = pass_o | fail_o;
    assign err_code_o  = err_code_q;
    assign match_cnt_o = match_q;
    assign ign_cnt_o   = ign_q;
    assign cycles_o    = cycles_q;
    assign err_addr_o  = err_addr_q;
    assign err_data_o  = err_data_q;

endmodule
